// File: rtl/sort_defs.sv
// Shared sorter/unsorter constants and the scatter FSM state encoding.
package sort_defs;

    localparam int SORT_NUMBER      = 6;
    localparam int SORT_DATA_LENGTH = 7;
    localparam int SORT_FLAG_LENGTH = 6;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SCATTER = 2'd1,
        ST_DONE    = 2'd2
    } scat_state_e;

endpackage

// File: rtl/unsort_slot_decode.sv
// Decodes a one-hot origin flag into a slot index and flags whether the code is legal.
module unsort_slot_decode #(
    parameter int FW = 6,
    parameter int SW = $clog2(FW)
) (
    input  logic [FW-1:0] flag,
    output logic [SW-1:0] slot,
    output logic          onehot_ok
);

    // Slot index from the highest set bit; only meaningful when onehot_ok is high.
    always_comb begin
        slot = '0;
        for (int j = 0; j < FW; j++) begin
            if (flag[j]) begin
                slot = SW'(j);
            end
        end
        onehot_ok = (flag != '0) && ((flag & (flag - FW'(1))) == '0);
    end

endmodule

// File: rtl/unsort_scatter.sv
// Rebuilds a sorted vector into original A1..A6 order, one element per clock,
// rejecting zero, multi-hot or repeated origin flags.
module unsort_scatter
    import sort_defs::*;
#(
    parameter int N  = SORT_NUMBER,
    parameter int DW = SORT_DATA_LENGTH,
    parameter int FW = SORT_FLAG_LENGTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            set,
    input  logic [DW*N-1:0] sort_data,
    input  logic [FW*N-1:0] sort_flag,
    output logic [DW*N-1:0] orig_data,
    output logic [N-1:0]    filled,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam int IW = $clog2(N);
    localparam int SW = $clog2(FW);

    scat_state_e     state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [DW*N-1:0] data_q, data_d;
    logic [FW*N-1:0] flag_q, flag_d;
    logic [DW*N-1:0] orig_q, orig_d;
    logic [N-1:0]    filled_q, filled_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic [DW-1:0]   elem_data_s;
    logic [FW-1:0]   elem_flag_s;
    logic [SW-1:0]   slot_s;
    logic            onehot_ok_s;
    logic            slot_free_s;
    logic            slot_ok_s;

    // Element idx is taken MSB-first from the latched vectors.
    always_comb begin
        elem_data_s = '0;
        elem_flag_s = '0;
        for (int k = 0; k < N; k++) begin
            if (idx_q == IW'(k)) begin
                elem_data_s = data_q[(N-1-k)*DW +: DW];
                elem_flag_s = flag_q[(N-1-k)*FW +: FW];
            end
        end
    end

    unsort_slot_decode #(.FW(FW), .SW(SW)) u_decode (
        .flag      (elem_flag_s),
        .slot      (slot_s),
        .onehot_ok (onehot_ok_s)
    );

    // A legal code is still rejected if an earlier element already claimed that slot.
    always_comb begin
        slot_free_s = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (slot_s == SW'(j)) begin
                slot_free_s = ~filled_q[j];
            end
        end
        slot_ok_s = onehot_ok_s & slot_free_s;
    end

    // Next-state logic: set restarts from any state, otherwise scatter one element per edge.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        data_d   = data_q;
        flag_d   = flag_q;
        orig_d   = orig_q;
        filled_d = filled_q;
        busy_d   = busy_q;
        done_d   = done_q;
        err_d    = err_q;
        if (set) begin
            data_d   = sort_data;
            flag_d   = sort_flag;
            orig_d   = '0;
            filled_d = '0;
            err_d    = 1'b0;
            done_d   = 1'b0;
            idx_d    = '0;
            busy_d   = 1'b1;
            state_d  = ST_SCATTER;
        end else begin
            case (state_q)
                ST_SCATTER: begin
                    if (slot_ok_s) begin
                        for (int j = 0; j < N; j++) begin
                            if (slot_s == SW'(j)) begin
                                orig_d[j*DW +: DW] = elem_data_s;
                                filled_d[j]        = 1'b1;
                            end
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                    if (idx_q == IW'(N-1)) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
                ST_IDLE, ST_DONE: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers; reset aborts any job at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            data_q   <= '0;
            flag_q   <= '0;
            orig_q   <= '0;
            filled_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            flag_q   <= flag_d;
            orig_q   <= orig_d;
            filled_q <= filled_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign orig_data = orig_q;
    assign filled    = filled_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_unsort_scatter.sv
// Scoreboard bench for unsort_scatter: jobs push a reference result, a monitor checks each completion.
module tb_unsort_scatter;

    localparam int N  = 6;
    localparam int DW = 7;
    localparam int FW = 6;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            set = 1'b0;
    logic [DW*N-1:0] sort_data = '0;
    logic [FW*N-1:0] sort_flag = '0;
    logic [DW*N-1:0] orig_data;
    logic [N-1:0]    filled;
    logic            busy, done, err;

    typedef struct {
        logic [DW*N-1:0] data;
        logic [N-1:0]    filled;
        logic            err;
        int              start;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic done_prev = 1'b0;

    unsort_scatter dut (
        .clk       (clk),
        .rst       (rst),
        .set       (set),
        .sort_data (sort_data),
        .sort_flag (sort_flag),
        .orig_data (orig_data),
        .filled    (filled),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: walk the elements in order, claim slots from single-bit flags, first writer wins.
    function automatic exp_t model(input logic [DW*N-1:0] d, input logic [FW*N-1:0] f);
        exp_t r;
        logic [FW-1:0] fe;
        r.data = '0; r.filled = '0; r.err = 1'b0; r.start = 0;
        for (int e = 0; e < N; e++) begin
            fe = f[(N-1-e)*FW +: FW];
            if ($countones(fe) == 1) begin
                int j;
                j = $clog2(fe);
                if (r.filled[j]) r.err = 1'b1;
                else begin
                    r.filled[j] = 1'b1;
                    r.data[j*DW +: DW] = d[(N-1-e)*DW +: DW];
                end
            end else begin
                r.err = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [DW*N-1:0] pack_d(input int v0, v1, v2, v3, v4, v5);
        return {DW'(v0), DW'(v1), DW'(v2), DW'(v3), DW'(v4), DW'(v5)};
    endfunction

    function automatic logic [FW*N-1:0] pack_f(input logic [FW-1:0] f0, f1, f2, f3, f4, f5);
        return {f0, f1, f2, f3, f4, f5};
    endfunction

    task automatic issue(input logic [DW*N-1:0] d, input logic [FW*N-1:0] f);
        exp_t e;
        @(negedge clk);
        sort_data = d;
        sort_flag = f;
        set = 1'b1;
        e = model(d, f);
        e.start = cyc;
        exp_q.push_back(e);
        @(negedge clk);
        set = 1'b0;
    endtask

    task automatic wait_done(input bit scramble);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            @(negedge clk);
            if (scramble) begin
                sort_data = (DW*N)'({$urandom(), $urandom()});
                sort_flag = (FW*N)'({$urandom(), $urandom()});
            end
        end
        check("job_timeout", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    // Monitor: every rising done retires the oldest outstanding job.
    always @(negedge clk) begin
        if (rst) begin
            done_prev <= 1'b0;
        end else begin
            if (done && !done_prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("orig_data", 64'(orig_data), 64'(e.data));
                    check("filled", 64'(filled), 64'(e.filled));
                    check("err", 64'(err), 64'(e.err));
                    check("busy_at_done", 64'(busy), 64'd0);
                    check("latency", 64'(cyc - e.start), 64'(N + 1));
                end
            end
            done_prev <= done;
        end
    end

    initial begin
        logic [DW*N-1:0] d_norm;
        logic [FW*N-1:0] f_norm;
        int p[N];
        logic [FW*N-1:0] f;

        d_norm = pack_d(5, 9, 12, 20, 33, 100);
        f_norm = pack_f(6'b000100, 6'b000001, 6'b100000, 6'b000010, 6'b010000, 6'b001000);

        #2;
        check("rst_orig", 64'(orig_data), 64'd0);
        check("rst_flags", 64'({filled, busy, done, err}), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Normal job, then confirm DONE holds its result.
        issue(d_norm, f_norm);
        wait_done(1'b0);
        repeat (3) @(negedge clk);
        check("done_hold", 64'(done), 64'd1);
        check("normal_const", 64'(orig_data), 64'(pack_d(12, 33, 100, 5, 20, 9)));

        // Duplicate A1 on e3, then two illegal flags.
        issue(d_norm, pack_f(6'b000100, 6'b000001, 6'b100000, 6'b000001, 6'b010000, 6'b001000));
        wait_done(1'b0);
        issue(d_norm, pack_f(6'b000100, 6'b000000, 6'b100000, 6'b000010, 6'b000011, 6'b001000));
        wait_done(1'b0);

        // Restart on the 3rd scatter edge with reversed flags.
        issue(d_norm, f_norm);
        @(negedge clk);
        void'(exp_q.pop_back());
        issue(pack_d(1, 2, 3, 4, 5, 6),
              pack_f(6'b100000, 6'b010000, 6'b001000, 6'b000100, 6'b000010, 6'b000001));
        wait_done(1'b0);

        // Asynchronous reset between edges mid-job.
        issue(d_norm, f_norm);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_orig", 64'(orig_data), 64'd0);
        check("async_rst_flags", 64'({filled, busy, done, err}), 64'd0);
        void'(exp_q.pop_back());
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_after_rst", 64'({filled, busy, done}), 64'd0);

        // Inputs scrambled every cycle after set.
        issue(d_norm, f_norm);
        wait_done(1'b1);

        // Random jobs: mostly permutations, some corrupted flags.
        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < N; i++) p[i] = i;
            for (int i = N - 1; i > 0; i--) begin
                int j, tmp;
                j = $urandom_range(i, 0);
                tmp = p[i]; p[i] = p[j]; p[j] = tmp;
            end
            f = '0;
            for (int e = 0; e < N; e++) f[(N-1-e)*FW +: FW] = FW'(1) << p[e];
            if ($urandom_range(2, 0) == 0) begin
                f[$urandom_range(N-1, 0)*FW +: FW] = FW'($urandom_range(63, 0));
            end
            issue((DW*N)'({$urandom(), $urandom()}), f);
            wait_done(t[0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
